// File: rtl/tick_pkg.sv
// Shared constants for the tick scheduler: bus widths, default tap/level
// settings, the state encoding and the level-to-tap mapping.
package tick_pkg;

    localparam int DIV_W   = 32;
    localparam int LEVEL_W = 3;
    localparam int COUNT_W = 8;
    localparam int STATE_W = 2;
    localparam int TAP_W   = 5;

    localparam int DEF_BASE_TAP        = 23;
    localparam int DEF_MAX_LEVEL       = 7;
    localparam int DEF_TICKS_PER_LEVEL = 16;

    typedef logic [STATE_W-1:0] state_t;

    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN    = 2'd1;
    localparam logic [STATE_W-1:0] ST_PAUSED = 2'd2;
    localparam logic [STATE_W-1:0] ST_MAXED  = 2'd3;

    // Each level halves the tick period by moving one divider bit lower.
    function automatic logic [TAP_W-1:0] tap_index(input int base_tap,
                                                   input logic [LEVEL_W-1:0] lvl);
        return TAP_W'(base_tap - int'(lvl));
    endfunction

endpackage

// File: rtl/tap_edge_detect.sv
// Rising-edge detector on the selected divider tap. A flush reloads both
// history stages from the current tap so a tap switch cannot fake an edge.
module tap_edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic tap,
    input  logic flush,
    output logic rise
);

    logic sel_q;
    logic sel_prev;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sel_q    <= 1'b0;
            sel_prev <= 1'b0;
        end else if (flush) begin
            sel_q    <= tap;
            sel_prev <= tap;
        end else begin
            sel_q    <= tap;
            sel_prev <= sel_q;
        end
    end

    assign rise = sel_q & ~sel_prev & ~flush;

endmodule

// File: rtl/tick_scheduler.sv
// Game-step tick scheduler: derives single-cycle ticks from a divider tap chosen
// by the speed level, and raises the level automatically or on request.
//
//   state  | meaning
//   IDLE   | waiting for start, level and tick_count at 0
//   RUN    | ticking, level climbs with ticks or speed_up
//   PAUSED | no ticks, level and tick_count frozen
//   MAXED  | ticking at the top level, tick_count free-wraps
module tick_scheduler
    import tick_pkg::*;
#(
    parameter int BASE_TAP        = DEF_BASE_TAP,
    parameter int MAX_LEVEL       = DEF_MAX_LEVEL,
    parameter int TICKS_PER_LEVEL = DEF_TICKS_PER_LEVEL
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [DIV_W-1:0]   divided_clocks,
    input  logic               start,
    input  logic               pause,
    input  logic               speed_up,
    output logic               tick,
    output logic [LEVEL_W-1:0] level,
    output logic [COUNT_W-1:0] tick_count,
    output logic [STATE_W-1:0] state
);

    localparam logic [LEVEL_W-1:0] LEVEL_TOP  = LEVEL_W'(MAX_LEVEL);
    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(TICKS_PER_LEVEL - 1);

    logic [TAP_W-1:0]   tap_sel;
    logic               tap_bit;
    logic               rise;
    logic               pause_q;
    logic               pause_rise;
    logic               level_changed;
    logic               running;
    logic               level_up;
    logic [STATE_W-1:0] state_next;
    logic [LEVEL_W-1:0] level_next;
    logic [COUNT_W-1:0] count_next;

    assign tap_sel = tap_index(BASE_TAP, level);
    assign tap_bit = divided_clocks[tap_sel];

    // level_changed is high for the first cycle on a new tap
    tap_edge_detect u_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .tap     (tap_bit),
        .flush   (level_changed),
        .rise    (rise)
    );

    assign running    = (state == ST_RUN) || (state == ST_MAXED);
    assign tick       = rise & running;
    assign pause_rise = pause & ~pause_q;

    always_comb begin
        state_next = state;
        level_next = level;
        count_next = tick_count;
        level_up   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                    level_next = '0;
                    count_next = '0;
                end
            end
            ST_RUN: begin
                // speed_up and an auto level-up in the same cycle still add one level
                level_up = speed_up || (tick && (tick_count == LAST_COUNT));
                if (level_up) begin
                    level_next = level + 1'b1;
                    count_next = '0;
                end else if (tick) begin
                    count_next = tick_count + 1'b1;
                end
                if (pause_rise) begin
                    state_next = ST_PAUSED;
                end else if (level_next == LEVEL_TOP) begin
                    state_next = ST_MAXED;
                end
            end
            ST_PAUSED: begin
                if (pause_rise) begin
                    state_next = (level == LEVEL_TOP) ? ST_MAXED : ST_RUN;
                end
            end
            ST_MAXED: begin
                if (tick) begin
                    count_next = tick_count + 1'b1;
                end
                if (pause_rise) begin
                    state_next = ST_PAUSED;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            level         <= '0;
            tick_count    <= '0;
            pause_q       <= 1'b0;
            level_changed <= 1'b0;
        end else begin
            state         <= state_next;
            level         <= level_next;
            tick_count    <= count_next;
            pause_q       <= pause;
            level_changed <= (level_next != level);
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: directed scenarios plus random
// stimulus, all compared cycle by cycle against a behavioural model.
module tb_tick_scheduler;

    localparam int BASE_TAP = 4;
    localparam int MAX_LEVEL = 3;
    localparam int TPL = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        speed_up = 1'b0;
    logic [31:0] divider = '0;
    logic        tick;
    logic [2:0]  level;
    logic [7:0]  tick_count;
    logic [1:0]  state;

    int n_compared = 0;
    int n_mismatched = 0;

    tick_scheduler #(
        .BASE_TAP        (BASE_TAP),
        .MAX_LEVEL       (MAX_LEVEL),
        .TICKS_PER_LEVEL (TPL)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .divided_clocks (divider),
        .start          (start),
        .pause          (pause),
        .speed_up       (speed_up),
        .tick           (tick),
        .level          (level),
        .tick_count     (tick_count),
        .state          (state)
    );

    always #10 clock = ~clock;
    always @(posedge clock) divider <= divider + 32'd1;

    // Reference model. A tick happens in a cycle when the current level's tap read
    // 0 two cycles ago and 1 one cycle ago, the level stayed the same across those
    // three cycles, and the scheduler is running. Reset cycles count as tap 0, level 0.
    int m_mode = 0;
    int m_level = 0;
    int m_count = 0;
    bit m_pause_q = 0;
    bit m_tick = 0;
    bit t1 = 0, t2 = 0;
    int l1 = 0, l2 = 0;
    int old_level;
    bit tap_now;
    bit pr;

    always @(posedge clock) begin
        old_level = m_level;
        tap_now = divider[BASE_TAP - m_level];
        if (!reset_n) begin
            m_mode = 0; m_level = 0; m_count = 0; m_pause_q = 0;
            tap_now = 0; old_level = 0;
        end else begin
            pr = pause && !m_pause_q;
            if (m_mode == 0) begin
                if (start) begin m_mode = 1; m_level = 0; m_count = 0; end
            end else if (m_mode == 1) begin
                if (speed_up || (m_tick && m_count == TPL - 1)) begin
                    m_level = m_level + 1; m_count = 0;
                end else if (m_tick) begin
                    m_count = m_count + 1;
                end
                if (pr) m_mode = 2;
                else if (m_level == MAX_LEVEL) m_mode = 3;
            end else if (m_mode == 2) begin
                if (pr) m_mode = (m_level == MAX_LEVEL) ? 3 : 1;
            end else begin
                if (m_tick) m_count = (m_count + 1) % 256;
                if (pr) m_mode = 2;
            end
            m_pause_q = pause;
        end
        t2 = t1; l2 = l1;
        t1 = tap_now; l1 = old_level;
        m_tick = (m_mode == 1 || m_mode == 3) && t1 && !t2 && m_level == l1 && l1 == l2;
    end

    logic [13:0] got_v, exp_v;
    assign got_v = {tick, level, tick_count, state};
    assign exp_v = {m_tick, 3'(m_level), 8'(m_count), 2'(m_mode)};

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; pause = 1'b0; speed_up = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_compared++;
        if (got_v !== 14'd0) begin
            n_mismatched++; $display("FAIL reset_state got=%h exp=%h", got_v, 14'd0);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1; reset_n = 1'b1;
            @(negedge clock);
            n_compared++;
            if (got_v !== exp_v) begin
                n_mismatched++; $display("FAIL reset_idle t=%0t got=%h exp=%h", $time, got_v, exp_v);
            end
        end
    endtask

    task automatic test_start();
        int waited, gap;
        @(posedge clock); #1; start = 1'b1;
        @(negedge clock);
        @(posedge clock); #1; start = 1'b0;
        @(negedge clock);
        n_compared++;
        if (state !== 2'd1) begin
            n_mismatched++; $display("FAIL start_run got=%0d exp=1", state);
        end
        waited = 0;
        while (tick !== 1'b1 && waited < 100) begin
            @(posedge clock); #1;
            @(negedge clock); waited++;
            n_compared++;
            if (got_v !== exp_v) begin
                n_mismatched++; $display("FAIL start_model t=%0t got=%h exp=%h", $time, got_v, exp_v);
            end
        end
        n_compared++;
        if (tick !== 1'b1 || divider[4:0] !== 5'd17) begin
            n_mismatched++; $display("FAIL first_tick got tick=%b div=%0d exp tick=1 div=17", tick, divider[4:0]);
        end
        gap = 0;
        do begin
            @(posedge clock); #1;
            @(negedge clock); gap++;
            n_compared++;
            if (got_v !== exp_v) begin
                n_mismatched++; $display("FAIL start_model t=%0t got=%h exp=%h", $time, got_v, exp_v);
            end
        end while (tick !== 1'b1 && gap < 100);
        n_compared++;
        if (gap != 32) begin
            n_mismatched++; $display("FAIL period_level0 got=%0d exp=32", gap);
        end
    endtask

    task automatic test_level_up();
        int waited, gap;
        waited = 0;
        while (level !== 3'd1 && waited < 200) begin
            @(posedge clock); #1;
            @(negedge clock); waited++;
            n_compared++;
            if (got_v !== exp_v) begin
                n_mismatched++; $display("FAIL levelup_model t=%0t got=%h exp=%h", $time, got_v, exp_v);
            end
        end
        n_compared++;
        if (level !== 3'd1 || tick_count !== 8'd0) begin
            n_mismatched++; $display("FAIL level_up got lvl=%0d cnt=%0d exp lvl=1 cnt=0", level, tick_count);
        end
        waited = 0;
        while (tick !== 1'b1 && waited < 64) begin
            @(posedge clock); #1;
            @(negedge clock); waited++;
            n_compared++;
            if (got_v !== exp_v) begin
                n_mismatched++; $display("FAIL levelup_model t=%0t got=%h exp=%h", $time, got_v, exp_v);
            end
        end
        n_compared++;
        if (tick !== 1'b1 || divider[3:0] !== 4'd9) begin
            n_mismatched++; $display("FAIL first_tick_level1 got tick=%b div=%0d exp tick=1 div=9", tick, divider[3:0]);
        end
        gap = 0;
        do begin
            @(posedge clock); #1;
            @(negedge clock); gap++;
            n_compared++;
            if (got_v !== exp_v) begin
                n_mismatched++; $display("FAIL levelup_model t=%0t got=%h exp=%h", $time, got_v, exp_v);
            end
        end while (tick !== 1'b1 && gap < 64);
        n_compared++;
        if (gap != 16) begin
            n_mismatched++; $display("FAIL period_level1 got=%0d exp=16", gap);
        end
    endtask

    task automatic test_pause();
        int delay, ticks, held_level, held_count, waited;
        delay = $urandom_range(0, 24);
        for (int i = 0; i <= delay + 1; i++) begin
            @(posedge clock); #1;
            if (i == delay) pause = 1'b1;
            @(negedge clock);
            n_compared++;
            if (got_v !== exp_v) begin
                n_mismatched++; $display("FAIL pause_model t=%0t got=%h exp=%h", $time, got_v, exp_v);
            end
        end
        n_compared++;
        if (state !== 2'd2) begin
            n_mismatched++; $display("FAIL pause_enter got=%0d exp=2", state);
        end
        held_level = m_level;
        held_count = m_count;
        ticks = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock); #1;
            if (i == 100) pause = 1'b0;
            @(negedge clock);
            if (tick === 1'b1) ticks++;
            n_compared++;
            if (level !== 3'(held_level) || tick_count !== 8'(held_count) || state !== 2'd2) begin
                n_mismatched++;
                $display("FAIL pause_hold got lvl=%0d cnt=%0d st=%0d exp lvl=%0d cnt=%0d st=2",
                         level, tick_count, state, held_level, held_count);
            end
        end
        n_compared++;
        if (ticks != 0) begin
            n_mismatched++; $display("FAIL pause_no_tick got=%0d exp=0", ticks);
        end
        @(posedge clock); #1; pause = 1'b1;
        @(negedge clock);
        waited = 0;
        while (tick !== 1'b1 && waited < 40) begin
            @(posedge clock); #1;
            @(negedge clock); waited++;
            n_compared++;
            if (got_v !== exp_v) begin
                n_mismatched++; $display("FAIL resume_model t=%0t got=%h exp=%h", $time, got_v, exp_v);
            end
        end
        n_compared++;
        if (tick !== 1'b1 || level !== 3'(held_level)) begin
            n_mismatched++; $display("FAIL pause_resume got tick=%b lvl=%0d exp tick=1 lvl=%0d", tick, level, held_level);
        end
        @(posedge clock); #1; pause = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_speed_up();
        int waited, gap;
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 4; i++) begin
                @(posedge clock); #1;
                speed_up = (i == 0);
                @(negedge clock);
                n_compared++;
                if (got_v !== exp_v) begin
                    n_mismatched++; $display("FAIL speedup_model t=%0t got=%h exp=%h", $time, got_v, exp_v);
                end
            end
        end
        n_compared++;
        if (level !== 3'd3 || state !== 2'd3) begin
            n_mismatched++; $display("FAIL speedup_max got lvl=%0d st=%0d exp lvl=3 st=3", level, state);
        end
        waited = 0;
        while (tick !== 1'b1 && waited < 20) begin
            @(posedge clock); #1;
            @(negedge clock); waited++;
        end
        gap = 0;
        do begin
            @(posedge clock); #1;
            @(negedge clock); gap++;
            n_compared++;
            if (got_v !== exp_v) begin
                n_mismatched++; $display("FAIL speedup_model t=%0t got=%h exp=%h", $time, got_v, exp_v);
            end
        end while (tick !== 1'b1 && gap < 20);
        n_compared++;
        if (gap != 4) begin
            n_mismatched++; $display("FAIL period_maxed got=%0d exp=4", gap);
        end
    endtask

    task automatic test_maxed_wrap();
        for (int i = 0; i < 1100; i++) begin
            @(posedge clock); #1;
            @(negedge clock);
            n_compared++;
            if (got_v !== exp_v) begin
                n_mismatched++; $display("FAIL wrap_model t=%0t got=%h exp=%h", $time, got_v, exp_v);
            end
        end
        n_compared++;
        if (state !== 2'd3 || level !== 3'd3) begin
            n_mismatched++; $display("FAIL maxed_stay got lvl=%0d st=%0d exp lvl=3 st=3", level, state);
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        @(posedge clock); #1; reset_n = 1'b0;
        @(negedge clock);
        @(posedge clock); #1; reset_n = 1'b1;
        @(negedge clock);
        n_compared++;
        if (got_v !== 14'd0) begin
            n_mismatched++; $display("FAIL reset_mid got=%h exp=%h", got_v, 14'd0);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            @(negedge clock);
            n_compared++;
            if (tick !== 1'b0 || state !== 2'd0 || got_v !== exp_v) begin
                n_mismatched++; $display("FAIL reset_idle_hold t=%0t got=%h exp=%h", $time, got_v, exp_v);
            end
        end
        @(posedge clock); #1; start = 1'b1;
        @(negedge clock);
        @(posedge clock); #1; start = 1'b0;
        @(negedge clock);
        waited = 0;
        while (tick !== 1'b1 && waited < 100) begin
            @(posedge clock); #1;
            @(negedge clock); waited++;
            n_compared++;
            if (got_v !== exp_v) begin
                n_mismatched++; $display("FAIL restart_model t=%0t got=%h exp=%h", $time, got_v, exp_v);
            end
        end
        n_compared++;
        if (tick !== 1'b1 || level !== 3'd0 || divider[4:0] !== 5'd17) begin
            n_mismatched++; $display("FAIL restart_tick got tick=%b lvl=%0d div=%0d exp tick=1 lvl=0 div=17",
                                     tick, level, divider[4:0]);
        end
    endtask

    task automatic test_random();
        logic prev_tick;
        prev_tick = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clock); #1;
            reset_n  = ($urandom_range(0, 599) != 0);
            start    = ($urandom_range(0, 39) == 0);
            speed_up = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 29) == 0) pause = ~pause;
            @(negedge clock);
            n_compared++;
            if (got_v !== exp_v) begin
                n_mismatched++; $display("FAIL random_model t=%0t got=%h exp=%h", $time, got_v, exp_v);
            end
            if (prev_tick === 1'b1) begin
                n_compared++;
                if (tick !== 1'b0) begin
                    n_mismatched++; $display("FAIL back_to_back t=%0t got=%b exp=0", $time, tick);
                end
            end
            prev_tick = tick;
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_level_up();
        test_pause();
        test_speed_up();
        test_maxed_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
